// File: rtl/step_sched_pkg.sv
// Shared definitions for the stepper move scheduler and the pmod step interfaces.
package step_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    localparam int CH_LID  = 0;
    localparam int CH_HAND = 1;

    // Step period must match the step interfaces, which import the same constant.
    localparam int DEF_STEP_DIV   = 250000;
    localparam int DEF_GAP_CYCLES = 1000000;

    function automatic logic [1:0] ch_onehot(input logic ch);
        return ch ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/step_move_scheduler_arb.sv
// Two-request round-robin arbiter: a lone request wins, a tie goes to the
// channel that was not served last.
module rr_arbiter2
    import step_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_served,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = ch_onehot(1'(CH_LID));
                2'b10:   grant = ch_onehot(1'(CH_HAND));
                2'b11:   grant = ch_onehot(~last_served);
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/step_move_scheduler.sv
// Serialises lid/hand stepper moves so only one motor is energised at a time,
// timing each move as steps*STEP_DIV enabled cycles followed by a settle gap.
//
// state | meaning
// IDLE  | arbitrating pending requests, req_ready valid for the granted channel
// RUN   | granted motor energised, counting step periods
// GAP   | settle time after a move, all motors off, no requests accepted
module step_move_scheduler
    import step_sched_pkg::*;
#(
    parameter int STEP_W     = 12,
    parameter int STEP_DIV   = DEF_STEP_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_dir,
    input  logic [2*STEP_W-1:0] req_steps,
    input  logic                abort,
    output logic [1:0]          en,
    output logic [1:0]          dir,
    output logic [1:0]          done,
    output logic                aborted,
    output logic                busy,
    output logic [STEP_W-1:0]   steps_left
);

    localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam sched_state_t ST_AFTER_MOVE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    sched_state_t        state, state_nxt;
    logic [TICK_W-1:0]   tick;
    logic [GAP_W-1:0]    gap_cnt;
    logic                last_served;
    logic                cur_ch;
    logic [1:0]          grant;
    logic                arb_en;
    logic                accept;
    logic                g_ch;
    logic                g_dir;
    logic [STEP_W-1:0]   g_steps;
    logic                step_wrap;
    logic                move_end;

    assign arb_en = (state == ST_IDLE) && !rst;

    rr_arbiter2 u_arb (
        .valid       (req_valid),
        .last_served (last_served),
        .enable      (arb_en),
        .grant       (grant)
    );

    assign accept    = |grant;
    assign g_ch      = grant[1];
    assign g_dir     = g_ch ? req_dir[1] : req_dir[0];
    assign g_steps   = g_ch ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
    // With STEP_DIV==1 every RUN cycle completes a step.
    assign step_wrap = (STEP_DIV == 1) || (tick == TICK_LAST);
    assign move_end  = abort || (step_wrap && (steps_left == STEP_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept && (g_steps != '0)) state_nxt = ST_RUN;
            ST_RUN:  if (move_end) state_nxt = ST_AFTER_MOVE;
            ST_GAP:  if (gap_cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        req_ready = grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick        <= '0;
            gap_cnt     <= '0;
            steps_left  <= '0;
            last_served <= 1'b1;
            cur_ch      <= 1'b0;
            en          <= '0;
            dir         <= '0;
            done        <= '0;
            aborted     <= 1'b0;
        end else begin
            done    <= '0;
            aborted <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        last_served <= g_ch;
                        cur_ch      <= g_ch;
                        steps_left  <= g_steps;
                        tick        <= '0;
                        if (g_steps != '0) begin
                            en[g_ch]  <= 1'b1;
                            dir[g_ch] <= g_dir;
                        end else begin
                            done[g_ch] <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Abort takes priority over a coincident final wrap.
                    if (abort) begin
                        en           <= '0;
                        done[cur_ch] <= 1'b1;
                        aborted      <= 1'b1;
                        gap_cnt      <= GAP_LOAD;
                    end else if (step_wrap) begin
                        tick       <= '0;
                        steps_left <= steps_left - 1'b1;
                        if (steps_left == STEP_W'(1)) begin
                            en           <= '0;
                            done[cur_ch] <= 1'b1;
                            gap_cnt      <= GAP_LOAD;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    a_one_motor: assert property (@(posedge clk) disable iff (rst) !(en[0] && en[1]));

endmodule

// File: tb/tb_step_move_scheduler.sv
// Scoreboard bench: instance 0 (STEP_DIV=4, GAP=3) and instance 1 (STEP_DIV=1, GAP=0)
// checked every cycle against a timeline model of moves, gaps and round-robin grants.
module tb_step_move_scheduler;

    localparam int SW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic [1:0]    req_valid  [2];
    logic [1:0]    req_ready  [2];
    logic [1:0]    req_dir    [2];
    logic [2*SW-1:0] req_steps [2];
    logic          abort      [2];
    logic [1:0]    en         [2];
    logic [1:0]    dir        [2];
    logic [1:0]    done       [2];
    logic          aborted    [2];
    logic          busy       [2];
    logic [SW-1:0] steps_left [2];

    step_move_scheduler #(.STEP_W(SW), .STEP_DIV(4), .GAP_CYCLES(3)) dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_dir(req_dir[0]), .req_steps(req_steps[0]), .abort(abort[0]), .en(en[0]),
        .dir(dir[0]), .done(done[0]), .aborted(aborted[0]), .busy(busy[0]),
        .steps_left(steps_left[0])
    );

    step_move_scheduler #(.STEP_W(SW), .STEP_DIV(1), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_dir(req_dir[1]), .req_steps(req_steps[1]), .abort(abort[1]), .en(en[1]),
        .dir(dir[1]), .done(done[1]), .aborted(aborted[1]), .busy(busy[1]),
        .steps_left(steps_left[1])
    );

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 3 : 0;
    endfunction

    typedef struct {
        int ch;
        bit ab;
        int sl;
        int at;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: a move accepted at cycle c energises cycles c+1 .. c+steps*DIV,
    // reports done one cycle later, then holds busy for GAP more cycles.
    bit         m_live     [2] = '{0, 0};
    bit         m_act      [2];
    bit         m_last     [2];
    int         m_idle_at  [2];
    int         m_start    [2];
    int         m_end      [2];
    int         m_steps    [2];
    int         m_ch       [2];
    int         m_sl_hold  [2];
    logic [1:0] m_dir      [2];

    task automatic chk(input string name, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc=%0d: got %0d, expected %0d", name, k, cyc, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic exp_t qfront(input int k);
        return (k == 0) ? sbq0[0] : sbq1[0];
    endfunction

    task automatic qpush(input int k, input exp_t e);
        if (k == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endtask

    task automatic qpop(input int k, output exp_t e);
        if (k == 0) e = sbq0.pop_front();
        else e = sbq1.pop_front();
    endtask

    task automatic qreplace_back(input int k, input exp_t e);
        if (k == 0) begin
            if (sbq0.size() > 0) void'(sbq0.pop_back());
            sbq0.push_back(e);
        end else begin
            if (sbq1.size() > 0) void'(sbq1.pop_back());
            sbq1.push_back(e);
        end
    endtask

    task automatic model_cycle(input int k);
        int         c;
        int         g;
        int         st;
        int         exp_sl;
        bit         in_run;
        logic [1:0] v;
        logic [1:0] exp_en;
        logic [1:0] exp_rdy;
        exp_t       e;
        c       = cyc;
        in_run  = 1'b0;
        exp_sl  = 0;
        v       = req_valid[k];
        exp_rdy = 2'b00;
        if (m_live[k]) begin
            in_run = m_act[k] && (c >= m_start[k]) && (c <= m_end[k]);
            exp_en = in_run ? (2'b01 << m_ch[k]) : 2'b00;
            exp_sl = in_run ? m_steps[k] - (c - m_start[k]) / div_of(k) : m_sl_hold[k];
            if (!rst[k] && (c >= m_idle_at[k])) begin
                if (v == 2'b11) exp_rdy = m_last[k] ? 2'b01 : 2'b10;
                else exp_rdy = v;
            end
            chk("en", k, int'(en[k]), int'(exp_en));
            chk("dir", k, int'(dir[k]), int'(m_dir[k]));
            chk("busy", k, int'(busy[k]), int'(c < m_idle_at[k]));
            chk("req_ready", k, int'(req_ready[k]), int'(exp_rdy));
            chk("steps_left", k, int'(steps_left[k]), exp_sl);
            if (done[k] != 2'b00) begin
                if (qsize(k) == 0) begin
                    chk("unexpected_done", k, int'(done[k]), 0);
                end else begin
                    qpop(k, e);
                    chk("done_ch", k, int'(done[k]), 1 << e.ch);
                    chk("done_cycle", k, c, e.at);
                    chk("done_aborted", k, int'(aborted[k]), int'(e.ab));
                    chk("done_steps_left", k, int'(steps_left[k]), e.sl);
                end
            end else begin
                chk("aborted_no_done", k, int'(aborted[k]), 0);
                if (qsize(k) != 0 && qfront(k).at < c) begin
                    qpop(k, e);
                    chk("done_missing", k, c, e.at);
                end
            end
        end
        if (rst[k]) begin
            m_live[k]    = 1'b1;
            m_act[k]     = 1'b0;
            m_last[k]    = 1'b1;
            m_idle_at[k] = c + 1;
            m_sl_hold[k] = 0;
            m_dir[k]     = 2'b00;
            if (k == 0) sbq0.delete();
            else sbq1.delete();
        end else if (m_live[k]) begin
            if (abort[k] && in_run) begin
                m_sl_hold[k] = exp_sl;
                m_end[k]     = c;
                m_idle_at[k] = c + 1 + ((gap_of(k) > 0) ? gap_of(k) + 1 : 0);
                qreplace_back(k, '{ch: m_ch[k], ab: 1'b1, sl: exp_sl, at: c + 1});
            end
            if ((v & exp_rdy) != 2'b00) begin
                g  = exp_rdy[1] ? 1 : 0;
                st = g ? int'(req_steps[k][2*SW-1:SW]) : int'(req_steps[k][SW-1:0]);
                m_last[k]    = g[0];
                m_sl_hold[k] = 0;
                if (st == 0) begin
                    m_idle_at[k] = c + 1;
                    qpush(k, '{ch: g, ab: 1'b0, sl: 0, at: c + 1});
                end else begin
                    m_act[k]     = 1'b1;
                    m_ch[k]      = g;
                    m_steps[k]   = st;
                    m_start[k]   = c + 1;
                    m_end[k]     = c + st * div_of(k);
                    m_dir[k][g]  = req_dir[k][g];
                    m_idle_at[k] = m_end[k] + 1 + ((gap_of(k) > 0) ? gap_of(k) + 1 : 0);
                    qpush(k, '{ch: g, ab: 1'b0, sl: 0, at: m_end[k] + 1});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_cycle(k);
    end

    // Advance one cycle; requests drop once their handshake has been taken.
    task automatic tick_cycle();
        logic [1:0] h0;
        logic [1:0] h1;
        @(negedge clk);
        h0 = req_valid[0] & req_ready[0];
        h1 = req_valid[1] & req_ready[1];
        @(posedge clk);
        #1;
        req_valid[0] = req_valid[0] & ~h0;
        req_valid[1] = req_valid[1] & ~h1;
        abort[0] = 1'b0;
        abort[1] = 1'b0;
        rst[0]   = 1'b0;
        rst[1]   = 1'b0;
    endtask

    task automatic issue(input int k, input int ch, input bit d, input int st);
        req_valid[k][ch] = 1'b1;
        req_dir[k][ch]   = d;
        if (ch == 0) req_steps[k][SW-1:0] = SW'(st);
        else req_steps[k][2*SW-1:SW] = SW'(st);
    endtask

    task automatic wait_accept(input int k, input int ch, input int budget);
        for (int n = 0; n < budget && req_valid[k][ch]; n++) tick_cycle();
        chk("accept_wait", k, int'(req_valid[k][ch]), 0);
    endtask

    task automatic wait_idle(input int k, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (cyc >= m_idle_at[k] && req_valid[k] == 2'b00 && qsize(k) == 0) break;
            tick_cycle();
        end
        chk("idle_wait", k, int'(busy[k]), 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 2'b00;
            req_dir[k]   = 2'b00;
            req_steps[k] = '0;
            abort[k]     = 1'b0;
        end
        repeat (2) begin
            rst[0] = 1'b1;
            rst[1] = 1'b1;
            tick_cycle();
        end

        // steps=3 dir=1 on the lid channel
        issue(0, 0, 1'b1, 3);
        wait_accept(0, 0, 10);
        wait_idle(0, 60);

        // contention right after reset: lid first, hand after the gap
        rst[0] = 1'b1;
        tick_cycle();
        issue(0, 0, 1'b0, 2);
        issue(0, 1, 1'b1, 1);
        wait_accept(0, 0, 10);
        wait_accept(0, 1, 40);
        wait_idle(0, 60);

        // zero-step hand command, lid accepted the very next cycle
        issue(0, 1, 1'b0, 0);
        wait_accept(0, 1, 10);
        issue(0, 0, 1'b1, 2);
        wait_accept(0, 0, 1);
        wait_idle(0, 60);

        // abort in the 6th enabled cycle of a 5-step move
        issue(0, 0, 1'b0, 5);
        wait_accept(0, 0, 10);
        repeat (5) tick_cycle();
        abort[0] = 1'b1;
        tick_cycle();
        wait_idle(0, 60);

        // reset mid-move, then a fresh hand request
        issue(0, 0, 1'b1, 4);
        wait_accept(0, 0, 10);
        repeat (3) tick_cycle();
        rst[0] = 1'b1;
        tick_cycle();
        issue(0, 1, 1'b1, 2);
        wait_accept(0, 1, 10);
        wait_idle(0, 60);

        // STEP_DIV=1 instance: two steps give two enabled cycles
        issue(1, 0, 1'b1, 2);
        wait_accept(1, 0, 10);
        wait_idle(1, 20);

        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 2; k++) begin
                for (int ch = 0; ch < 2; ch++) begin
                    if (!req_valid[k][ch] && $urandom_range(0, 5) == 0)
                        issue(k, ch, 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
                end
                if ($urandom_range(0, 29) == 0) abort[k] = 1'b1;
                if ($urandom_range(0, 299) == 0) rst[k] = 1'b1;
            end
            tick_cycle();
        end
        wait_idle(0, 400);
        wait_idle(1, 400);
        repeat (2) tick_cycle();
        chk("final_queue", 0, qsize(0), 0);
        chk("final_queue", 1, qsize(1), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
